// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signal bundle for the hazard/forwarding controller.
// master = pipeline datapath, slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_multicycle;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_dst;
  logic              wb_regwrite;
  logic              branch_taken;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_rs;
  logic              id_byp_rt;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              id_ex_bubble;
  logic              ex_mem_bubble;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_multicycle,
           ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread,
           mem_dst, mem_regwrite, wb_dst, wb_regwrite, branch_taken,
    input  fwd_a, fwd_b, id_byp_rs, id_byp_rt, pc_write, if_id_write,
           id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush,
           id_ex_flush, ex_mem_flush, mc_busy, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_multicycle,
           ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread,
           mem_dst, mem_regwrite, wb_dst, wb_regwrite, branch_taken,
    output fwd_a, fwd_b, id_byp_rs, id_byp_rt, pc_write, if_id_write,
           id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush,
           id_ex_flush, ex_mem_flush, mc_busy, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use interlock, multi-cycle EXE occupancy and branch flush.
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// RUN   | normal issue; forwarding, load-use and flush only
// MC    | multi-cycle op holds EXE; front end frozen until cnt reaches 1
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_unit_if.slave hz
);

  typedef enum logic {ST_RUN, ST_MC} state_t;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [7:0]        MC_LOAD  = 8'(MC_LAT - 1);
  localparam bit                MC_EN    = (MC_LAT > 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lu;

  always_comb begin
    hz.fwd_a = 2'b00;
    if (hz.mem_regwrite && hz.mem_dst != REG_ZERO && hz.mem_dst == hz.ex_rs)
      hz.fwd_a = 2'b01;
    else if (hz.wb_regwrite && hz.wb_dst != REG_ZERO && hz.wb_dst == hz.ex_rs)
      hz.fwd_a = 2'b10;

    hz.fwd_b = 2'b00;
    if (hz.mem_regwrite && hz.mem_dst != REG_ZERO && hz.mem_dst == hz.ex_rt)
      hz.fwd_b = 2'b01;
    else if (hz.wb_regwrite && hz.wb_dst != REG_ZERO && hz.wb_dst == hz.ex_rt)
      hz.fwd_b = 2'b10;

    hz.id_byp_rs = hz.wb_regwrite && hz.wb_dst != REG_ZERO &&
                   hz.wb_dst == hz.id_rs && hz.id_uses_rs;
    hz.id_byp_rt = hz.wb_regwrite && hz.wb_dst != REG_ZERO &&
                   hz.wb_dst == hz.id_rt && hz.id_uses_rt;

    lu = hz.ex_memread && hz.ex_dst != REG_ZERO &&
         ((hz.id_uses_rs && hz.ex_dst == hz.id_rs) ||
          (hz.id_uses_rt && hz.ex_dst == hz.id_rt));
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    hz.pc_write      = 1'b1;
    hz.if_id_write   = 1'b1;
    hz.id_ex_write   = 1'b1;
    hz.id_ex_bubble  = 1'b0;
    hz.ex_mem_bubble = 1'b0;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.ex_mem_flush  = 1'b0;

    if (hz.branch_taken) begin
      // Taken branch squashes everything younger, including an in-flight MC op.
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
      state_d         = ST_RUN;
      cnt_d           = 8'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (lu) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
          end else if (hz.id_multicycle && MC_EN) begin
            state_d = ST_MC;
            cnt_d   = MC_LOAD;
          end
        end
        ST_MC: begin
          hz.pc_write      = 1'b0;
          hz.if_id_write   = 1'b0;
          hz.id_ex_write   = 1'b0;
          hz.ex_mem_bubble = 1'b1;
          cnt_d            = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign hz.mc_busy = (state_q == ST_MC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!hz.pc_write && stall_cycles_q != {CNT_W{1'b1}})
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (hz.branch_taken && flush_events_q != {CNT_W{1'b1}})
      flush_events_d = flush_events_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, hand-written
// multi-cycle/flush/reset sequences, and random traffic against a model.
module tb_hazard_forward_unit;
  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_forward_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_multicycle = 0; bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_dst = '0;
    bus.ex_regwrite = 0; bus.ex_memread = 0; bus.mem_dst = '0;
    bus.mem_regwrite = 0; bus.wb_dst = '0; bus.wb_regwrite = 0;
    bus.branch_taken = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] ex_rs, ex_rt, mem_dst; logic mem_rw;
    logic [4:0] wb_dst; logic wb_rw;
    logic [4:0] id_rs, id_rt; logic u_rs, u_rt;
    logic [4:0] ex_dst; logic ex_mr;
    int e_fa, e_fb, e_brs, e_brt, e_pc, e_bub;
  } vec_t;

  vec_t vecs[9];

  // Reference model: forwarding from the written priority rule
  function automatic int fsel(int src, bit mrw, int md, bit wrw, int wd);
    if (mrw && md != 0 && md == src) return 1;
    if (wrw && wd != 0 && wd == src) return 2;
    return 0;
  endfunction

  int mc_left, m_stall, m_flush;

  task automatic model_step_check(input string tag);
    bit lu, busy, br;
    int pc, ifid, idex, idexb, exmb, fl;
    lu = bus.ex_memread && bus.ex_dst != 0 &&
         ((bus.id_uses_rs && bus.ex_dst == bus.id_rs) ||
          (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
    busy = (mc_left > 0);
    br = bus.branch_taken;
    pc = 1; ifid = 1; idex = 1; idexb = 0; exmb = 0; fl = br ? 1 : 0;
    if (!br && busy) begin
      pc = 0; ifid = 0; idex = 0; exmb = 1;
    end else if (!br && lu) begin
      pc = 0; ifid = 0; idexb = 1;
    end
    chk({tag, "_fwd_a"}, int'(bus.fwd_a), fsel(bus.ex_rs, bus.mem_regwrite, bus.mem_dst, bus.wb_regwrite, bus.wb_dst));
    chk({tag, "_fwd_b"}, int'(bus.fwd_b), fsel(bus.ex_rt, bus.mem_regwrite, bus.mem_dst, bus.wb_regwrite, bus.wb_dst));
    chk({tag, "_byp"}, int'({bus.id_byp_rs, bus.id_byp_rt}),
        ((bus.wb_regwrite && bus.wb_dst != 0 && bus.wb_dst == bus.id_rs && bus.id_uses_rs) ? 2 : 0) +
        ((bus.wb_regwrite && bus.wb_dst != 0 && bus.wb_dst == bus.id_rt && bus.id_uses_rt) ? 1 : 0));
    chk({tag, "_ctl"},
        int'({bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.id_ex_bubble, bus.ex_mem_bubble,
              bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mc_busy}),
        (pc << 8) | (ifid << 7) | (idex << 6) | (idexb << 5) | (exmb << 4) |
        (fl << 3) | (fl << 2) | (fl << 1) | (busy ? 1 : 0));
    if (pc == 0 && m_stall < (1 << CNT_W) - 1) m_stall++;
    if (br && m_flush < (1 << CNT_W) - 1) m_flush++;
    if (br) mc_left = 0;
    else if (busy) mc_left--;
    else if (bus.id_multicycle && !lu && MC_LAT > 1) mc_left = MC_LAT - 1;
  endtask

  initial begin
    int busy_n;
    vecs[0] = '{5'd5, 5'd0, 5'd5, 1, 5'd5, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 1, 0};
    vecs[1] = '{5'd5, 5'd0, 5'd5, 0, 5'd5, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2, 0, 0, 0, 1, 0};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{5'd3, 5'd7, 5'd7, 1, 5'd3, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2, 1, 0, 0, 1, 0};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 0, 5'd9, 1, 5'd9, 5'd4, 1, 1, 5'd0, 0, 0, 0, 1, 0, 1, 0};
    vecs[5] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd8, 0, 1, 5'd8, 1, 0, 0, 0, 0, 0, 1};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd8, 0, 0, 5'd8, 1, 0, 0, 0, 0, 1, 0};
    vecs[7] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0, 1, 0};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 0, 5'd8, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 0, 1, 0, 0, 1};

    drive_idle();
    #3;
    chk("rst_mc_busy", int'(bus.mc_busy), 0);
    chk("rst_pc_write", int'(bus.pc_write), 1);
    chk("rst_stall_cnt", int'(bus.stall_cycles), 0);
    do_reset();

    // Vector table (RUN state, no branch/multicycle)
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.ex_rs = vecs[i].ex_rs; bus.ex_rt = vecs[i].ex_rt;
      bus.mem_dst = vecs[i].mem_dst; bus.mem_regwrite = vecs[i].mem_rw;
      bus.wb_dst = vecs[i].wb_dst; bus.wb_regwrite = vecs[i].wb_rw;
      bus.id_rs = vecs[i].id_rs; bus.id_rt = vecs[i].id_rt;
      bus.id_uses_rs = vecs[i].u_rs; bus.id_uses_rt = vecs[i].u_rt;
      bus.ex_dst = vecs[i].ex_dst; bus.ex_memread = vecs[i].ex_mr;
      #2;
      chk($sformatf("vec%0d_fwd_a", i), int'(bus.fwd_a), vecs[i].e_fa);
      chk($sformatf("vec%0d_fwd_b", i), int'(bus.fwd_b), vecs[i].e_fb);
      chk($sformatf("vec%0d_byp", i), int'({bus.id_byp_rs, bus.id_byp_rt}), vecs[i].e_brs * 2 + vecs[i].e_brt);
      chk($sformatf("vec%0d_stall", i), int'({bus.pc_write, bus.if_id_write, bus.id_ex_bubble}),
          vecs[i].e_pc * 6 + vecs[i].e_bub);
    end

    // Load-use together with a multicycle op: lu wins, MC entered on re-presentation
    do_reset();
    @(negedge clk);
    bus.ex_memread = 1; bus.ex_dst = 5'd8; bus.id_rt = 5'd8; bus.id_uses_rt = 1; bus.id_multicycle = 1;
    #2 chk("lu_mc_pc_write", int'(bus.pc_write), 0);
    @(negedge clk);
    bus.ex_memread = 0; bus.mem_dst = 5'd8; bus.mem_regwrite = 1;
    #2 chk("lu_mc_deferred", int'(bus.mc_busy), 0);
    chk("lu_mc_represent_pc", int'(bus.pc_write), 1);
    @(negedge clk);
    bus.id_multicycle = 0;
    #2 chk("lu_mc_entered", int'(bus.mc_busy), 1);

    // Multi-cycle occupancy: exactly MC_LAT-1 busy cycles
    do_reset();
    @(negedge clk);
    bus.id_multicycle = 1;
    #2 chk("mc_entry_pc_write", int'(bus.pc_write), 1);
    @(negedge clk);
    bus.id_multicycle = 0;
    busy_n = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (bus.mc_busy) busy_n++;
      if (k == 0) chk("mc_ex_mem_bubble", int'(bus.ex_mem_bubble), 1);
      @(negedge clk);
    end
    chk("mc_busy_cycles", busy_n, MC_LAT - 1);
    chk("mc_stall_cnt", int'(bus.stall_cycles), PERF ? MC_LAT - 1 : 0);

    // Branch in the second MC cycle aborts the op
    do_reset();
    @(negedge clk);
    bus.id_multicycle = 1;
    @(negedge clk);
    bus.id_multicycle = 0;
    @(negedge clk);
    bus.branch_taken = 1;
    #2 chk("br_flushes", int'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 7);
    chk("br_pc_write", int'(bus.pc_write), 1);
    @(negedge clk);
    bus.branch_taken = 0;
    #2 chk("br_mc_busy_after", int'(bus.mc_busy), 0);
    chk("br_flush_cnt", int'(bus.flush_events), PERF ? 1 : 0);
    chk("br_stall_cnt", int'(bus.stall_cycles), PERF ? 1 : 0);

    // Asynchronous reset mid-MC
    do_reset();
    @(negedge clk);
    bus.id_multicycle = 1;
    @(negedge clk);
    bus.id_multicycle = 0;
    #2 chk("ar_pre_busy", int'(bus.mc_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy_now", int'(bus.mc_busy), 0);
    chk("ar_stall_now", int'(bus.stall_cycles), 0);
    chk("ar_pc_write_now", int'(bus.pc_write), 1);
    repeat (2) @(posedge clk);
    #1 chk("ar_busy_held", int'(bus.mc_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ar_busy_after_release", int'(bus.mc_busy), 0);
    chk("ar_pc_after_release", int'(bus.pc_write), 1);

    // Random traffic against the model
    do_reset();
    mc_left = 0; m_stall = 0; m_flush = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
      bus.id_multicycle = ($urandom_range(0, 5) == 0);
      bus.ex_rs = 5'($urandom_range(0, 3)); bus.ex_rt = 5'($urandom_range(0, 3));
      bus.ex_dst = 5'($urandom_range(0, 3)); bus.ex_regwrite = 1'($urandom);
      bus.ex_memread = ($urandom_range(0, 3) == 0);
      bus.mem_dst = 5'($urandom_range(0, 3)); bus.mem_regwrite = 1'($urandom);
      bus.wb_dst = 5'($urandom_range(0, 3)); bus.wb_regwrite = 1'($urandom);
      bus.branch_taken = ($urandom_range(0, 11) == 0);
      #2 model_step_check("rnd");
      @(posedge clk);
      #1;
      chk("rnd_stall_cnt", int'(bus.stall_cycles), PERF ? m_stall : 0);
      chk("rnd_flush_cnt", int'(bus.flush_events), PERF ? m_flush : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
